// File: rtl/tmr_mon_pkg.sv
// Shared types and constants for the TMR disagreement monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tmr_mon_pkg;

  // Per-channel tracker state
  typedef enum logic [1:0] {
    TRK_OK      = 2'd0,
    TRK_SUSPECT = 2'd1,
    TRK_FAILED  = 2'd2
  } trk_state_e;

  localparam int CH_A     = 0;
  localparam int CH_B     = 1;
  localparam int CH_C     = 2;
  localparam int NUM_CH   = 3;
  localparam int EV_CNT_W = 16;

  // Isolate the lowest set bit; zero in, zero out.
  function automatic logic [NUM_CH-1:0] lowest_onehot(input logic [NUM_CH-1:0] v);
    return v & (~v + 3'd1);
  endfunction

endpackage

// File: rtl/tmr_disagree_monitor_if.sv
// Bundle of sample/compare inputs and fault-report outputs of the monitor.
// Latency: n/a (wiring only).
// Backpressure: fault_valid/fault_ready handshake; optional ev_cnt_* under TMR_MON_EVENT_CNT_EN.
interface tmr_disagree_monitor_if
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH = 26
);
  logic             sample;
  logic [WIDTH-1:0] ch_a;
  logic [WIDTH-1:0] ch_b;
  logic [WIDTH-1:0] ch_c;
  logic [WIDTH-1:0] voted_n;
  logic             clr;
  logic [2:0]       miss;
  logic [2:0]       failed;
  logic             multi_fail;
  logic             fault_valid;
  logic [2:0]       fault_chan;
  logic             fault_ready;
`ifdef TMR_MON_EVENT_CNT_EN
  logic [EV_CNT_W-1:0] ev_cnt_a;
  logic [EV_CNT_W-1:0] ev_cnt_b;
  logic [EV_CNT_W-1:0] ev_cnt_c;

  modport master (
    output sample, ch_a, ch_b, ch_c, voted_n, clr, fault_ready,
    input  miss, failed, multi_fail, fault_valid, fault_chan,
    input  ev_cnt_a, ev_cnt_b, ev_cnt_c
  );
  modport slave (
    input  sample, ch_a, ch_b, ch_c, voted_n, clr, fault_ready,
    output miss, failed, multi_fail, fault_valid, fault_chan,
    output ev_cnt_a, ev_cnt_b, ev_cnt_c
  );
`else
  modport master (
    output sample, ch_a, ch_b, ch_c, voted_n, clr, fault_ready,
    input  miss, failed, multi_fail, fault_valid, fault_chan
  );
  modport slave (
    input  sample, ch_a, ch_b, ch_c, voted_n, clr, fault_ready,
    output miss, failed, multi_fail, fault_valid, fault_chan
  );
`endif
endinterface

// File: rtl/tmr_chan_tracker.sv
// One channel: compare vs majority, OK/SUSPECT/FAILED tracking, pending report bit, optional event counter (TMR_MON_EVENT_CNT_EN).
// Latency: a sample is reflected in miss/failed/pending on the next cycle.
// Backpressure: pending holds until ack; clr overrides sample and ack.
module tmr_chan_tracker
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH   = 26,
  parameter int PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic             clr,
  input  logic             ack,
  input  logic [WIDTH-1:0] ch,
  input  logic [WIDTH-1:0] maj,
  output logic             miss,
  output logic             failed,
  output logic             pending
`ifdef TMR_MON_EVENT_CNT_EN
  ,
  output logic [EV_CNT_W-1:0] ev_cnt
`endif
);

  localparam int            CW       = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERSIST - 1);

  trk_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          miss_q, miss_d;
  logic          pend_q, pend_d;
  logic          mis;

  assign mis = |(ch ^ maj);

  // State, counter, mismatch and pending registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRK_OK;
      cnt_q   <= '0;
      miss_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      pend_q  <= pend_d;
    end
  end

  // Next state: clr wins, then ack clears pending, then a sample advances the tracker
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    pend_d  = pend_q;
    if (clr) begin
      state_d = TRK_OK;
      cnt_d   = '0;
      miss_d  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      if (ack) pend_d = 1'b0;
      if (sample) begin
        miss_d = mis;
        case (state_q)
          TRK_OK: begin
            if (mis) begin
              if (PERSIST == 1) begin
                state_d = TRK_FAILED;
                pend_d  = 1'b1;
              end else begin
                state_d = TRK_SUSPECT;
                cnt_d   = CNT_ONE;
              end
            end
          end
          TRK_SUSPECT: begin
            if (mis) begin
              cnt_d = cnt_q + CNT_ONE;
              if (cnt_q == CNT_LAST) begin
                state_d = TRK_FAILED;
                pend_d  = 1'b1;
              end
            end else begin
              state_d = TRK_OK;
              cnt_d   = '0;
            end
          end
          default: ;  // FAILED is sticky until clr or reset
        endcase
      end
    end
  end

  assign miss    = miss_q;
  assign failed  = (state_q == TRK_FAILED);
  assign pending = pend_q;

`ifdef TMR_MON_EVENT_CNT_EN
  logic [EV_CNT_W-1:0] ev_q;

  // Saturating count of every sampled mismatch; survives clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q <= '0;
    end else if (sample && !clr && mis && (ev_q != '1)) begin
      ev_q <= ev_q + 1'b1;
    end
  end

  assign ev_cnt = ev_q;
`endif

endmodule

// File: rtl/tmr_disagree_monitor.sv
// TMR disagreement monitor: three channel trackers, lowest-index-first fault report arbiter, multi_fail.
// Latency: sample in cycle N shows on outputs in N+1; accept in N presents next report in N+1.
// Backpressure: a report holds on fault_valid until fault_ready; reports queue in pending bits (A, B, C order).
module tmr_disagree_monitor
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH   = 26,
  parameter int PERSIST = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  tmr_disagree_monitor_if.slave mon
);

  logic [WIDTH-1:0]  maj;
  logic [WIDTH-1:0]  chan_w [NUM_CH];
  logic [NUM_CH-1:0] miss_v, failed_v, pend_v, ack_v, sel_v;
`ifdef TMR_MON_EVENT_CNT_EN
  logic [EV_CNT_W-1:0] ev_v [NUM_CH];
`endif

  assign maj            = ~mon.voted_n;
  assign chan_w[CH_A]   = mon.ch_a;
  assign chan_w[CH_B]   = mon.ch_b;
  assign chan_w[CH_C]   = mon.ch_c;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tmr_chan_tracker #(
      .WIDTH  (WIDTH),
      .PERSIST(PERSIST)
    ) u_trk (
      .clk    (clk),
      .rst_n  (rst_n),
      .sample (mon.sample),
      .clr    (mon.clr),
      .ack    (ack_v[i]),
      .ch     (chan_w[i]),
      .maj    (maj),
      .miss   (miss_v[i]),
      .failed (failed_v[i]),
      .pending(pend_v[i])
`ifdef TMR_MON_EVENT_CNT_EN
      ,
      .ev_cnt (ev_v[i])
`endif
    );
  end

  // Report arbiter: present the lowest pending channel, ack it on handshake
  always_comb begin
    sel_v = lowest_onehot(pend_v);
    ack_v = mon.fault_ready ? sel_v : '0;
  end

  assign mon.miss        = miss_v;
  assign mon.failed      = failed_v;
  assign mon.multi_fail  = (failed_v[CH_A] & failed_v[CH_B]) |
                           (failed_v[CH_A] & failed_v[CH_C]) |
                           (failed_v[CH_B] & failed_v[CH_C]);
  assign mon.fault_valid = |pend_v;
  assign mon.fault_chan  = sel_v;

`ifdef TMR_MON_EVENT_CNT_EN
  assign mon.ev_cnt_a = ev_v[CH_A];
  assign mon.ev_cnt_b = ev_v[CH_B];
  assign mon.ev_cnt_c = ev_v[CH_C];
`endif

endmodule

// File: doc/tmr_disagree_monitor.md
# tmr_disagree_monitor

Disagreement monitor for one triple-modular-redundant word path. It sits directly downstream of a bank of per-bit 2-of-3 voters: it consumes the three pre-vote channel words and the voter's inverted-majority output word. It tracks persistent per-channel disagreement and raises latched channel-fault reports through a valid/ready handshake to the error-handling logic. It also flags loss of redundancy when two or more channels have failed.

## Interface
- `WIDTH`, 26: bits per channel word.
- `PERSIST`, 4: consecutive disagreeing samples before a channel is declared failed; legal range 1..255.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sample` in 1: qualifies inputs this cycle; when low, all inputs are ignored.
- `ch_a`, `ch_b`, `ch_c` in WIDTH: pre-vote channel words.
- `voted_n` in WIDTH: voter output, bitwise inverted majority of the enabled channels.
- `clr` in 1: one-cycle pulse that returns all channels to healthy.
- `miss` out 3: registered per-channel mismatch from the last sample. Bit 0 is A, bit 1 is B, bit 2 is C.
- `failed` out 3: per-channel FAILED state.
- `multi_fail` out 1: high when two or more bits of `failed` are set.
- `fault_valid` out 1: a fault report is pending.
- `fault_chan` out 3: one-hot channel of the current report; 0 when `fault_valid` is low.
- `fault_ready` in 1: consumer accepts the report.
- `ev_cnt_a`, `ev_cnt_b`, `ev_cnt_c` out 16: present only with `TMR_MON_EVENT_CNT_EN`.

## Operation
- Reference word is `maj = ~voted_n`. A channel mismatches when `ch_x != maj` in any bit (OR-reduce of the XOR).
- Each channel has a 3-state tracker: OK, SUSPECT, FAILED, plus a counter `cnt` of width `$clog2(PERSIST+1)`.
- OK, sampled with a mismatch:
  - `PERSIST == 1`: go to FAILED.
  - otherwise: go to SUSPECT with cnt=1.
- OK, sampled with a match: stay in OK.
- SUSPECT, sampled with a mismatch: cnt+1. When cnt+1 == PERSIST, go to FAILED.
- SUSPECT, sampled with a match: go to OK with cnt=0 (consecutive count, not cumulative).
- FAILED is sticky. It ignores samples and leaves only on `clr` or reset.
- When `sample` is low, tracker state, `cnt` and `miss` all hold.
- On every transition into FAILED the channel's pending bit is set.
- `fault_valid` = OR of the pending bits. `fault_chan` = lowest-index pending bit, one-hot.
- On `fault_valid && fault_ready` that pending bit clears on the next edge.
- Channels failing in the same cycle are reported in successive handshakes, A before B before C.
- `clr` has priority over everything: any `sample` in that cycle is discarded. `clr` zeroes all states, counters, pending bits and `miss`.
- Event counters are unaffected by `clr`.
- All three channels mismatching in one sample (possible with per-bit splits) are tracked independently; no special case.

## Timing
- All outputs are registered.
- A sample in cycle N is reflected in `miss`, `failed`, `multi_fail` and `fault_valid` in cycle N+1.
- Accept in cycle N: the next pending channel is presented, or `fault_valid` drops, in cycle N+1. Back-to-back accepts give one report per cycle.
- A new failure and an accept in the same cycle: the accepted bit clears and the new bit sets; `fault_valid` stays high.
- Reset values: `miss` = 0, `failed` = 0, `multi_fail` = 0, `fault_valid` = 0, `fault_chan` = 0, `ev_cnt_*` = 0. All trackers are OK with cnt 0.
- Assertion of `rst_n` mid-report drops the report immediately (asynchronous).

## Configuration
- `TMR_MON_EVENT_CNT_EN` defined:
  - Each channel has a 16-bit counter that increments on every sampled mismatch, including while FAILED.
  - Counters saturate at 0xFFFF and clear only on reset.
  - `ev_cnt_a`, `ev_cnt_b` and `ev_cnt_c` exist.
- `TMR_MON_EVENT_CNT_EN` undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package `tmr_mon_pkg` holds:
  - tracker state enum (`TRK_OK`, `TRK_SUSPECT`, `TRK_FAILED`);
  - channel index constants `CH_A` = 0, `CH_B` = 1, `CH_C` = 2;
  - the event counter width constant (16).
- Sub-module `tmr_chan_tracker` is instantiated three times. It contains the compare, state, counter, pending bit and optional event counter.
- The top level holds the report arbiter and `multi_fail`.

## Test plan
- Reset: hold `rst_n` low, then release. All outputs are 0 and `fault_valid` stays 0 under matching samples.
- Basic fault, `PERSIST` = 4: `ch_b` differs from `maj` in bit 3 for 4 consecutive samples.
  - `miss` = 3'b010 from the first sample on.
  - `failed` = 3'b010 and `fault_valid` = 1 with `fault_chan` = 3'b010 one cycle after the 4th sample.
- Non-consecutive disagreement: B mismatches 3 samples, matches 1, mismatches 3. B is never FAILED.
- Idle cycles and simultaneous failure: `sample` low between mismatches does not reset `cnt`. With A and C failing in the same cycle and `fault_ready` held high:
  - reports 3'b001 then 3'b100 on consecutive cycles;
  - then `fault_valid` = 0;
  - `multi_fail` = 1.
- Clear priority: `clr` asserted in the same cycle as the PERSIST-th mismatch. The channel stays OK, with no report and `miss` = 0.
- With `TMR_MON_EVENT_CNT_EN`: 70000 sampled mismatches on C give `ev_cnt_c` = 16'hFFFF, and `clr` leaves it unchanged.
